// File: rtl/irq_pkg.sv
// Shared definitions for the nested interrupt controller.
//   id_width() : index width for a given channel count (minimum 1 bit)
//   irq_mode_e : per-channel trigger mode encoding
//   vec_calc() : handler address = base + id * stride (caller truncates)
package irq_pkg;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } irq_mode_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] vec_calc(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] id);
    return base + id * stride;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder.
//   req_i   : request vector, bit 0 has the highest priority
//   valid_o : at least one request bit is set
//   idx_o   : index of the lowest set bit (0 when none)
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ = 8
) (
  input  logic [N_IRQ-1:0]           req_i,
  output logic                       valid_o,
  output logic [id_width(N_IRQ)-1:0] idx_o
);

  localparam int unsigned ID_W = id_width(N_IRQ);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (req_i[i] && !valid_o) begin
        valid_o = 1'b1;
        idx_o   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_nested.sv
// Nested, fixed-priority interrupt controller with a bounded ISR stack.
//   clk, reset      : clock (rising edge), asynchronous active-low reset
//   irq             : raw asynchronous interrupt lines
//   irq_mode        : per channel, 1 = rising edge, 0 = level high
//   irq_en, glb_en  : per-channel and global enables
//   take, reti      : strobes from the control unit
//   irq_req/id/vec  : registered request, winning channel, handler address
//   in_isr, cur_id  : ISR active flag, innermost active channel
//   depth           : current nesting level
//   pending         : pending register
//   reti_err        : sticky flag for reti at depth 0
module irq_ctrl_nested
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ      = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned VEC_BASE   = 'h3C0,
  parameter int unsigned VEC_STRIDE = 4,
  parameter int unsigned NEST_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_IRQ-1:0]                  irq,
  input  logic [N_IRQ-1:0]                  irq_mode,
  input  logic [N_IRQ-1:0]                  irq_en,
  input  logic                              glb_en,
  input  logic                              take,
  input  logic                              reti,
  output logic                              irq_req,
  output logic [id_width(N_IRQ)-1:0]        irq_id,
  output logic [ADDR_W-1:0]                 irq_vec,
  output logic                              in_isr,
  output logic [id_width(N_IRQ)-1:0]        cur_id,
  output logic [$clog2(NEST_DEPTH+1)-1:0]   depth,
  output logic [N_IRQ-1:0]                  pending,
  output logic                              reti_err
);

  localparam int unsigned ID_W  = id_width(N_IRQ);
  localparam int unsigned DEP_W = $clog2(NEST_DEPTH + 1);

  logic [N_IRQ-1:0]  sync1_q, sync2_q, prev_q;
  logic [N_IRQ-1:0]  pend_q, pend_d, clr;
  logic [ID_W-1:0]   stack_q [NEST_DEPTH];
  logic [ID_W-1:0]   stack_d [NEST_DEPTH];
  logic [ID_W-1:0]   cur_id_q, cur_id_d, pop_val;
  logic [DEP_W-1:0]  depth_q, depth_d;
  logic              req_q, req_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic              err_q, err_d;
  logic              take_ok, pop_ok;
  logic [N_IRQ-1:0]  elig;
  logic              win_valid;
  logic [ID_W-1:0]   win_idx;

  assign take_ok = take & req_q;
  assign pop_ok  = reti & (depth_q != '0);

  // Level channels load sync1 so pending tracks sync2 in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      clr[i] = take_ok && (id_q == ID_W'(i));
      if (irq_mode[i] == MODE_EDGE)
        pend_d[i] = (sync2_q[i] & ~prev_q[i]) | (pend_q[i] & ~clr[i]);
      else
        pend_d[i] = sync1_q[i];
    end
  end

  assign elig = pend_q & irq_en & {N_IRQ{glb_en}};

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .req_i   (elig),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  always_comb begin
    req_d = win_valid && ((depth_q == '0) || (win_idx < cur_id_q)) &&
            (depth_q < DEP_W'(NEST_DEPTH)) && !take;
    id_d  = req_d ? win_idx : '0;
    vec_d = req_d ? ADDR_W'(vec_calc(VEC_BASE, VEC_STRIDE, 32'(win_idx))) : '0;
  end

  // take+reti together replaces the innermost ISR without touching the stack.
  always_comb begin
    stack_d  = stack_q;
    cur_id_d = cur_id_q;
    depth_d  = depth_q;
    err_d    = err_q | (reti & (depth_q == '0));
    pop_val  = '0;
    for (int unsigned i = 0; i < NEST_DEPTH; i++)
      if (depth_q == DEP_W'(i + 1)) pop_val = stack_q[i];
    if (take_ok && pop_ok) begin
      cur_id_d = id_q;
    end else if (take_ok) begin
      for (int unsigned i = 0; i < NEST_DEPTH; i++)
        if (depth_q == DEP_W'(i)) stack_d[i] = cur_id_q;
      cur_id_d = id_q;
      depth_d  = depth_q + DEP_W'(1);
    end else if (pop_ok) begin
      cur_id_d = pop_val;
      depth_d  = depth_q - DEP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      pend_q   <= '0;
      stack_q  <= '{default: '0};
      cur_id_q <= '0;
      depth_q  <= '0;
      req_q    <= 1'b0;
      id_q     <= '0;
      vec_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= irq;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      pend_q   <= pend_d;
      stack_q  <= stack_d;
      cur_id_q <= cur_id_d;
      depth_q  <= depth_d;
      req_q    <= req_d;
      id_q     <= id_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
    end
  end

  assign irq_req  = req_q;
  assign irq_id   = id_q;
  assign irq_vec  = vec_q;
  assign in_isr   = (depth_q != '0);
  assign cur_id   = cur_id_q;
  assign depth    = depth_q;
  assign pending  = pend_q;
  assign reti_err = err_q;

endmodule

// File: tb/tb_irq_ctrl_nested.sv
// Directed bench: one default instance (nesting depth 4) and one with
// nesting depth 2; both share every input.
module tb_irq_ctrl_nested;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq, irq_mode, irq_en;
  logic       glb_en, take, reti;

  logic       req, in_isr, err;
  logic [2:0] id, cid, dep;
  logic [9:0] vec;
  logic [7:0] pend;

  logic       req2, in_isr2, err2;
  logic [2:0] id2, cid2;
  logic [1:0] dep2;
  logic [9:0] vec2;
  logic [7:0] pend2;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

  always #5 clk = ~clk;

  irq_ctrl_nested dut (
    .clk(clk), .reset(reset), .irq(irq), .irq_mode(irq_mode), .irq_en(irq_en),
    .glb_en(glb_en), .take(take), .reti(reti), .irq_req(req), .irq_id(id),
    .irq_vec(vec), .in_isr(in_isr), .cur_id(cid), .depth(dep), .pending(pend),
    .reti_err(err)
  );

  irq_ctrl_nested #(.NEST_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .irq(irq), .irq_mode(irq_mode), .irq_en(irq_en),
    .glb_en(glb_en), .take(take), .reti(reti), .irq_req(req2), .irq_id(id2),
    .irq_vec(vec2), .in_isr(in_isr2), .cur_id(cid2), .depth(dep2),
    .pending(pend2), .reti_err(err2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_take();
    take = 1'b1; tick(); take = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1; tick(); reti = 1'b0;
  endtask

  // Bounded wait for a request on either instance.
  task automatic wait_req(input bit sel, input string tag);
    int unsigned n = 0;
    while (((sel ? req2 : req) !== 1'b1) && n < 12) begin
      tick();
      n++;
    end
    check(tag, sel ? req2 : req, 1);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    tick(2);
    #2 reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; irq = '0; irq_mode = 8'hFF; irq_en = 8'hFF;
    glb_en = 1'b1; take = 1'b0; reti = 1'b0;
    tick(2);
    check("rst_req", req, 0);
    check("rst_depth", dep, 0);
    check("rst_pend", pend, 0);
    check("rst_err", err, 0);
    #2 reset = 1'b1;
    tick();

    // Single edge IRQ with exact latency
    irq = 8'h08;
    tick(3);
    check("lat_pend_k2", pend[3], 1);
    check("lat_req_k2", req, 0);
    tick();
    check("lat_req_k3", req, 1);
    check("e_id", id, 3);
    check("e_vec", vec, 10'h3CC);
    pulse_take();
    check("e_depth", dep, 1);
    check("e_cur", cid, 3);
    check("e_pend", pend[3], 0);
    check("e_req_take", req, 0);
    tick();
    check("e_req_after", req, 0);
    check("e_in_isr", in_isr, 1);

    // Preemption
    irq = 8'h0A;
    wait_req(0, "p_req1");
    check("p_id1", id, 1);
    check("p_vec1", vec, 10'h3C4);
    pulse_take();
    check("p_depth2", dep, 2);
    check("p_cur1", cid, 1);
    irq = 8'h2A;
    tick(6);
    check("p_no_req5", req, 0);
    check("p_pend5", pend[5], 1);
    pulse_reti();
    check("p_cur3", cid, 3);
    check("p_depth1", dep, 1);
    tick(3);
    check("p_no_req5b", req, 0);
    pulse_reti();
    check("p_depth0", dep, 0);
    check("p_cur0", cid, 0);
    wait_req(0, "p_req5");
    check("p_id5", id, 5);
    check("p_vec5", vec, 10'h3D4);
    pulse_take();
    pulse_reti();
    irq = '0;
    tick(4);

    // Level mode on channel 2
    irq_mode = 8'hFB;
    irq = 8'h04;
    wait_req(0, "l_req");
    check("l_id", id, 2);
    check("l_vec", vec, 10'h3C8);
    pulse_take();
    check("l_depth", dep, 1);
    check("l_pend_kept", pend[2], 1);
    tick(3);
    check("l_no_self", req, 0);
    pulse_reti();
    wait_req(0, "l_reassert");
    check("l_id2", id, 2);
    pulse_take();
    irq = '0;
    tick(4);
    check("l_pend_drop", pend[2], 0);
    pulse_reti();
    tick(3);
    check("l_no_req", req, 0);
    check("l_depth0", dep, 0);
    irq_mode = 8'hFF;

    // Nest full on the depth-2 instance
    do_reset();
    irq = 8'h40;
    wait_req(1, "n_req6");
    check("n_id6", id2, 6);
    pulse_take();
    irq = 8'h50;
    wait_req(1, "n_req4");
    check("n_id4", id2, 4);
    pulse_take();
    check("n_depth2", dep2, 2);
    check("n_cur4", cid2, 4);
    irq = 8'h51;
    tick(6);
    check("n_full_req", req2, 0);
    check("n_full_pend", pend2[0], 1);
    check("n_wide_req", req, 1);
    pulse_reti();
    check("n_cur6", cid2, 6);
    wait_req(1, "n_req0");
    check("n_id0", id2, 0);
    check("n_vec0", vec2, 10'h3C0);
    pulse_take();
    check("n_depth_big", dep, 2);

    // Async reset mid-ISR
    #3 reset = 1'b0;
    #1;
    check("ar_depth", dep, 0);
    check("ar_in_isr", in_isr, 0);
    check("ar_cur", cid, 0);
    check("ar_req", req, 0);
    check("ar_id", id, 0);
    check("ar_vec", vec, 0);
    check("ar_pend", pend, 0);
    check("ar_depth2", dep2, 0);
    irq = '0;
    tick(2);
    #2 reset = 1'b1;
    tick();

    // Corner strobes
    pulse_reti();
    check("c_err", err, 1);
    check("c_err_depth", dep, 0);
    irq = 8'h20;
    wait_req(0, "c_req5");
    pulse_take();
    check("c_cur5", cid, 5);
    irq = 8'h24;
    wait_req(0, "c_req2");
    check("c_id2", id, 2);
    take = 1'b1; reti = 1'b1;
    tick();
    take = 1'b0; reti = 1'b0;
    check("c_tr_depth", dep, 1);
    check("c_tr_cur", cid, 2);
    check("c_tr_pend", pend[2], 0);
    check("c_err_sticky", err, 1);
    tick(2);
    check("c_idle_req", req, 0);
    pulse_take();
    check("c_ign_depth", dep, 1);
    check("c_ign_cur", cid, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
